hilo_unit: RTL
==============

Name: hilo_unit

Overview:
- Downstream consumer of the divider and multiplier in the MIPS ALU datapath.
- Tracks one outstanding mult/div operation from issue to completion.
- Captures the 64-bit result into the architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO with stall interlocks, a timeout watchdog and diagnostic flags.

Parameters:
WIDTH, 32, HI/LO register width; result bus is 2*WIDTH.
CNT_W, 16, width of the busy-cycle counter.
TIMEOUT, 65535, busy cycles after which the pending operation is abandoned (must be < 2^CNT_W).

Ports:
CLK  in  1  single clock, rising edge.
Reset  in  1  synchronous, active-high.
Issue  in  1  request to start a mult/div; accepted only when IssueReady=1.
IssueKind  in  1  0=mult, 1=div; sampled on an accepted Issue.
IssueReady  out  1  high in IDLE only.
ResValid  in  1  one-cycle pulse from the divider or multiplier: result present.
ResData  in  2*WIDTH  divider: [2W-1:W]=quotient, [W-1:0]=remainder; multiplier: {upper,lower}.
RdReq  in  1  MFHI/MFLO request.
RdSel  in  1  0=LO, 1=HI.
RdData  out  WIDTH  selected register, combinational from HI/LO.
RdStall  out  1  RdReq & BUSY.
WrEn  in  1  MTHI/MTLO.
WrSel  in  1  0=LO, 1=HI.
WrData  in  WIDTH  value to write.
WrStall  out  1  WrEn & BUSY; the write is not performed.
Busy  out  1  state==BUSY.
CycleCount  out  CNT_W  busy cycles of the current or last operation.
Timeout  out  1  sticky; set on watchdog expiry.
Spurious  out  1  sticky; set by ResValid in IDLE.

Behaviour:
- Reset, synchronous active-high, takes priority over everything:
  - state=IDLE; HI=LO=0; CycleCount=0; Timeout=Spurious=0; the pending operation is dropped.
  - A ResValid arriving later is treated as spurious.
- IDLE:
  - Issue=1 → BUSY on the next edge; latch IssueKind into PendKind; CycleCount←0.
  - WrEn=1 → HI or LO ← WrData on the edge.
  - ResValid=1 → results ignored; Spurious←1.
- BUSY:
  - CycleCount increments each cycle, saturating at 2^CNT_W-1.
  - ResValid=1, PendKind=div: LO←ResData[2W-1:W] (quotient), HI←ResData[W-1:0] (remainder).
  - ResValid=1, PendKind=mult: HI←ResData[2W-1:W], LO←ResData[W-1:0].
  - Either ResValid case → IDLE on the same edge.
  - CycleCount==TIMEOUT and no ResValid → IDLE; Timeout←1; HI/LO unchanged.
  - ResValid in the expiry cycle wins: result is written, Timeout is not set.
  - Issue is ignored (IssueReady=0).
  - WrEn: the write is dropped and WrStall=1; the requester must hold WrEn.
  - RdReq: RdStall=1 and RdData shows stale HI/LO; the requester must hold RdReq.
- Result write latency: HI/LO are visible on RdData in the cycle after the ResValid edge. There is no same-cycle forwarding.
- Simultaneous events:
  - WrEn and Issue together in IDLE: both take effect; the write lands before BUSY.
  - RdReq and WrEn together in IDLE to the same register: RdData shows the old value.
- Timeout and Spurious clear only on Reset.
- No arithmetic is performed in this block. Widths pass through unchanged.

Decomposition:
- Shared ALU package holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1
  - kind constants: KIND_MUL=0, KIND_DIV=1
  - select constants: SEL_LO=0, SEL_HI=1
- One natural sub-module: hilo_busy_counter, the saturating CNT_W counter with clear and a terminal-count compare against TIMEOUT.
- HI/LO storage and the FSM stay in the top module.

Test Plan:
- Div writeback: Issue kind=div; 5 cycles later ResValid with ResData={32'd14,32'd2} (100/7) → LO=14, HI=2; CycleCount=5; Busy drops after the edge; IssueReady=1.
- Mult writeback: Issue kind=mul; ResValid with ResData=64'h00000001_FFFFFFFE → HI=1, LO=FFFFFFFE; RdSel=1 reads 1 the next cycle.
- Interlocks: during BUSY, RdReq=1 → RdStall=1; WrEn=1, WrSel=0, WrData=5 → WrStall=1 and LO unchanged; after ResValid both stalls drop and the held MTLO writes LO=5.
- Watchdog (TIMEOUT=8): Issue with no ResValid → after 8 busy cycles, IDLE and Timeout=1 with HI/LO unchanged; a later ResValid → Spurious=1, HI/LO unchanged.
- Reset mid-operation: Issue, 3 cycles, Reset=1 for one cycle → IDLE, HI=LO=0, flags 0; the following ResValid is ignored and sets Spurious.
- MT/MF in IDLE: WrEn, WrSel=1, WrData=DEADBEEF → next cycle RdSel=1 gives DEADBEEF; LO is still 0.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// Shared encodings for the HI/LO writeback block of the MIPS ALU datapath.
package hilo_unit_pkg;

    // Tracking state: either no mult/div outstanding, or exactly one.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hilo_state_t;

    // Kind of the outstanding operation, latched on issue.
    localparam logic KIND_MUL = 1'b0;
    localparam logic KIND_DIV = 1'b1;

    // Register select for MFHI/MFLO/MTHI/MTLO.
    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/hilo_busy_counter.sv
// Saturating busy-cycle counter with clear and a watchdog terminal-count flag.
// tc marks the busy cycle whose closing edge brings the count up to TIMEOUT,
// so the watchdog fires after exactly TIMEOUT busy cycles and the count
// left behind reads TIMEOUT. TIMEOUT is expected to be at least 1.
module hilo_busy_counter
    import hilo_unit_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_reg;

    // Count busy cycles; clear on a new issue, hold at all-ones.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign tc    = en && (count_reg == TC_VAL);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with mult/div completion tracking, MF/MT
// stall interlocks, a busy watchdog and sticky diagnostic flags.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Issue,
    input  logic               IssueKind,
    output logic               IssueReady,
    input  logic               ResValid,
    input  logic [2*WIDTH-1:0] ResData,
    input  logic               RdReq,
    input  logic               RdSel,
    output logic [WIDTH-1:0]   RdData,
    output logic               RdStall,
    input  logic               WrEn,
    input  logic               WrSel,
    input  logic [WIDTH-1:0]   WrData,
    output logic               WrStall,
    output logic               Busy,
    output logic [CNT_W-1:0]   CycleCount,
    output logic               Timeout,
    output logic               Spurious
);

    hilo_state_t      state_reg, state_next;
    logic             pend_kind_reg, pend_kind_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             timeout_reg, timeout_next;
    logic             spurious_reg, spurious_next;
    logic             cnt_clr;
    logic             cnt_tc;
    logic             busy;

    // Upper/lower halves of the result bus as delivered by the producers.
    logic [WIDTH-1:0] res_upper;
    logic [WIDTH-1:0] res_lower;

    assign res_upper = ResData[2*WIDTH-1:WIDTH];
    assign res_lower = ResData[WIDTH-1:0];
    assign busy      = (state_reg == BUSY);

    hilo_busy_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_busy_counter (
        .clk   (CLK),
        .srst  (Reset),
        .clr   (cnt_clr),
        .en    (busy),
        .count (CycleCount),
        .tc    (cnt_tc)
    );

    // Next-state, register writeback and flag updates.
    always_comb begin
        state_next     = state_reg;
        pend_kind_next = pend_kind_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        timeout_next   = timeout_reg;
        spurious_next  = spurious_reg;
        cnt_clr        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // An MT write in the issue cycle lands before BUSY begins.
                if (WrEn) begin
                    if (WrSel == SEL_HI) hi_next = WrData;
                    else                 lo_next = WrData;
                end
                if (ResValid) spurious_next = 1'b1;
                if (Issue) begin
                    state_next     = BUSY;
                    pend_kind_next = IssueKind;
                    cnt_clr        = 1'b1;
                end
            end
            BUSY: begin
                // A result in the watchdog's final cycle still wins.
                if (ResValid) begin
                    if (pend_kind_reg == KIND_DIV) begin
                        lo_next = res_upper;
                        hi_next = res_lower;
                    end else begin
                        hi_next = res_upper;
                        lo_next = res_lower;
                    end
                    state_next = IDLE;
                end else if (cnt_tc) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, HI/LO storage and sticky flags; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg     <= IDLE;
            pend_kind_reg <= KIND_MUL;
            hi_reg        <= '0;
            lo_reg        <= '0;
            timeout_reg   <= 1'b0;
            spurious_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_kind_reg <= pend_kind_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            timeout_reg   <= timeout_next;
            spurious_reg  <= spurious_next;
        end
    end

    assign IssueReady = ~busy;
    assign Busy       = busy;
    assign RdData     = (RdSel == SEL_HI) ? hi_reg : lo_reg;
    assign RdStall    = RdReq & busy;
    assign WrStall    = WrEn & busy;
    assign Timeout    = timeout_reg;
    assign Spurious   = spurious_reg;

endmodule
